// File: rtl/conv_out_serializer.sv
// Pixel FIFO that drains six channel words per pixel over a ready/valid port.
// It tags each beat with its channel and a frame-end flag, and latches a sticky overflow.
module conv_out_serializer #(
    parameter int unsigned IMG_Width  = 3,
    parameter int unsigned IMG_Height = 3,
    parameter int unsigned Datawidth  = 32,
    parameter int unsigned Depth      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    input  logic [Datawidth-1:0] In_4,
    input  logic [Datawidth-1:0] In_5,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Datawidth-1:0] Out_data,
    output logic [2:0]           Out_ch,
    output logic                 Out_last,
    output logic                 overflow
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned NPix = IMG_Width * IMG_Height;
    localparam int unsigned PixW = (NPix > 1) ? $clog2(NPix) : 1;
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(Depth);
    localparam logic [PixW-1:0] LastPix = PixW'(NPix - 1);

    logic [Datawidth-1:0] mem_q [Depth][6];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [2:0]      ch_q, ch_d;
    logic [PixW-1:0] pix_q, pix_d;
    logic            overflow_q, overflow_d;

    logic beat, pop, push, drop;

    always_comb begin
        out_valid = (count_q != '0);
        beat      = out_valid & out_ready;
        pop       = beat & (ch_q == 3'd5);
        // A full FIFO can still take a pixel in the cycle its head is popped.
        push      = valid_in & ((count_q < FullCnt) | pop);
        drop      = valid_in & ~push;

        Out_data  = out_valid ? mem_q[rd_ptr_q][ch_q] : '0;
        Out_ch    = ch_q;
        Out_last  = out_valid & (ch_q == 3'd5) & (pix_q == LastPix);
        overflow  = overflow_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        overflow_d = overflow_q | drop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (beat) begin
            ch_d = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            pix_d    = (pix_q == LastPix) ? '0 : pix_q + PixW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ch_q       <= 3'd0;
            pix_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the read side is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q][0] <= In_0;
            mem_q[wr_ptr_q][1] <= In_1;
            mem_q[wr_ptr_q][2] <= In_2;
            mem_q[wr_ptr_q][3] <= In_3;
            mem_q[wr_ptr_q][4] <= In_4;
            mem_q[wr_ptr_q][5] <= In_5;
        end
    end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Bench for conv_out_serializer: directed scenarios plus random traffic.
// All of it is checked every cycle against a queue-based model of the pixel stream.
module tb_conv_out_serializer;

    localparam int unsigned W    = 3;
    localparam int unsigned H    = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned DEP  = 4;
    localparam int unsigned NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] in_w [6];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] Out_data;
    logic [2:0]    Out_ch;
    logic          Out_last;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of whole pixels, word index into the head, frame position, sticky flag.
    typedef logic [DW-1:0] pixel_t [6];
    pixel_t m_q [$];
    int     m_ch;
    int     m_pix;
    bit     m_ovf;

    conv_out_serializer #(
        .IMG_Width (W),
        .IMG_Height(H),
        .Datawidth (DW),
        .Depth     (DEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .In_0     (in_w[0]),
        .In_1     (in_w[1]),
        .In_2     (in_w[2]),
        .In_3     (in_w[3]),
        .In_4     (in_w[4]),
        .In_5     (in_w[5]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out_data (Out_data),
        .Out_ch   (Out_ch),
        .Out_last (Out_last),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ch  = 0;
        m_pix = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        bit            v;
        logic [DW-1:0] d;
        v = (m_q.size() != 0);
        d = v ? m_q[0][m_ch] : '0;
        check("out_valid", {63'd0, out_valid}, {63'd0, v});
        check("Out_data", {32'd0, Out_data}, {32'd0, d});
        check("Out_ch", {61'd0, Out_ch}, 64'(m_ch));
        check("Out_last", {63'd0, Out_last},
              {63'd0, v && m_ch == 5 && m_pix == NPIX - 1});
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic step(input bit vin, input pixel_t px, input bit rdy);
        bit popped;
        @(negedge clk);
        check_outputs();
        valid_in  = vin;
        out_ready = rdy;
        for (int i = 0; i < 6; i++) in_w[i] = px[i];
        @(posedge clk);
        popped = 1'b0;
        if (m_q.size() != 0 && rdy) begin
            if (m_ch == 5) begin
                void'(m_q.pop_front());
                m_ch   = 0;
                m_pix  = (m_pix + 1) % NPIX;
                popped = 1'b1;
            end else begin
                m_ch++;
            end
        end
        if (vin) begin
            if (m_q.size() < DEP || popped) m_q.push_back(px);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic pixel_t mk_px(input int base, input int stride);
        pixel_t p;
        for (int i = 0; i < 6; i++) p[i] = DW'(base * stride + i);
        return p;
    endfunction

    function automatic pixel_t rnd_px();
        pixel_t p;
        for (int i = 0; i < 6; i++) p[i] = $urandom;
        return p;
    endfunction

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, rnd_px(), rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        pixel_t p;
        int bp;
        for (int i = 0; i < 6; i++) in_w[i] = '0;
        model_reset();
        #12;
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_data", {32'd0, Out_data}, 64'd0);
        check("reset_ovf", {63'd0, overflow}, 64'd0);
        rst = 1'b1;

        // Single pixel 10..15 with the sink always ready.
        p = mk_px(10, 1);
        for (int i = 0; i < 6; i++) p[i] = DW'(10 + i);
        step(1'b1, p, 1'b1);
        idle(8, 1'b1);

        // Backpressure pattern 1,0,0 repeating.
        do_reset();
        step(1'b1, p, 1'b1);
        bp = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, rnd_px(), (bp == 0));
            bp = (bp + 1) % 3;
        end

        // Frame flag: 10 pixels, word = pixel*8 + channel, spaced 6 cycles apart.
        do_reset();
        for (int px = 0; px < 10; px++) begin
            step(1'b1, mk_px(px, 8), 1'b1);
            idle(5, 1'b1);
        end
        idle(3, 1'b1);

        // Overflow: 5 back-to-back pixels into a stalled sink, then drain.
        do_reset();
        for (int px = 0; px < 5; px++) step(1'b1, mk_px(px + 1, 8), 1'b0);
        idle(3, 1'b0);
        idle(28, 1'b1);

        // Full FIFO with a push landing on the channel-5 beat.
        do_reset();
        for (int px = 0; px < 4; px++) step(1'b1, mk_px(px, 8), 1'b0);
        idle(5, 1'b1);
        step(1'b1, mk_px(4, 8), 1'b1);
        idle(2, 1'b0);
        check("full_pop_ovf", {63'd0, overflow}, 64'd0);
        idle(30, 1'b1);

        // Async reset between edges in the middle of a drain.
        do_reset();
        for (int px = 0; px < 3; px++) step(1'b1, rnd_px(), 1'b0);
        idle(4, 1'b1);
        #2;
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        check("async_valid", {63'd0, out_valid}, 64'd0);
        check("async_ch", {61'd0, Out_ch}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int px = 0; px < 10; px++) begin
            step(1'b1, rnd_px(), 1'b1);
            idle(5, 1'b1);
        end

        // Random traffic across several input/ready densities.
        do_reset();
        for (int phase = 0; phase < 4; phase++) begin
            int pv;
            int pr;
            pv = 5 + phase * 10;
            pr = 40 + phase * 15;
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(99) < pv), rnd_px(), ($urandom_range(99) < pr));
            end
        end
        idle(40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
